// File: rtl/universal_shifter_pipe.sv
// universal_shifter_pipe: pipelined barrel shifter with valid/ready handshake.
// Stage gi applies a conditional shift of 2**gi selected by k[gi], so a full
// shift needs SHW register stages. A stall at the output freezes every stage,
// and bubbles carry zero data so out reads 0 whenever out_valid is low.
module universal_shifter_pipe #(
  parameter int WIDTH = 8,
  parameter int SHW   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] z,
  input  logic [SHW-1:0]   k,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out
);

  localparam logic [1:0] MODE_LSL = 2'b00;
  localparam logic [1:0] MODE_LSR = 2'b01;
  localparam logic [1:0] MODE_ASR = 2'b10;

  // Whole-pipe freeze: a finished result is waiting and the consumer refuses it.
  logic w_stall;

  for (genvar gi = 0; gi < SHW; gi++) begin : gen_stage
    localparam int SH = 1 << gi;

    // Inputs to this stage; k narrows by one bit per stage as bits are consumed.
    logic [WIDTH-1:0]  w_data_in;
    logic [SHW-gi-1:0] w_k_in;
    logic [1:0]        w_mode_in;
    logic              w_vld_in;
    logic [WIDTH-1:0]  w_shifted;
    logic [WIDTH-1:0]  w_data_next;

    logic [WIDTH-1:0]  r_data;
    logic              r_vld;

    if (gi == 0) begin : g_src
      assign w_data_in = z;
      assign w_k_in    = k;
      assign w_mode_in = mode;
      assign w_vld_in  = in_valid & in_ready;
    end else begin : g_src
      assign w_data_in = gen_stage[gi-1].r_data;
      assign w_k_in    = gen_stage[gi-1].g_carry.r_k;
      assign w_mode_in = gen_stage[gi-1].g_carry.r_mode;
      assign w_vld_in  = gen_stage[gi-1].r_vld;
    end

    // Fixed-distance shift by 2**gi in the requested mode. Arithmetic shifts
    // keep the MSB intact, so the stage MSB is still the original sign bit.
    always_comb begin
      w_shifted = w_data_in;
      case (w_mode_in)
        MODE_LSL: w_shifted = w_data_in << SH;
        MODE_LSR: w_shifted = w_data_in >> SH;
        MODE_ASR: w_shifted = WIDTH'($signed(w_data_in) >>> SH);
        default:  w_shifted = (w_data_in >> SH) | (w_data_in << (WIDTH - SH));
      endcase
    end

    // Apply the shift only when this stage's k bit is set; bubbles carry zero.
    assign w_data_next = !w_vld_in ? '0 : (w_k_in[0] ? w_shifted : w_data_in);

    // Data and valid advance together unless the output is stalled.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_data <= '0;
        r_vld  <= 1'b0;
      end else if (!w_stall) begin
        r_data <= w_data_next;
        r_vld  <= w_vld_in;
      end
    end

    // Every stage but the last forwards the unused k bits and the mode.
    if (gi < SHW - 1) begin : g_carry
      logic [SHW-gi-2:0] r_k;
      logic [1:0]        r_mode;

      // Control fields follow the data through the pipe under the same stall.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_k    <= '0;
          r_mode <= 2'b00;
        end else if (!w_stall) begin
          r_k    <= w_k_in[SHW-gi-1:1];
          r_mode <= w_mode_in;
        end
      end
    end
  end

  assign out       = gen_stage[SHW-1].r_data;
  assign out_valid = gen_stage[SHW-1].r_vld;
  assign w_stall   = out_valid & ~out_ready;
  assign in_ready  = ~w_stall;

endmodule
